powlib_ffarb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered output stage among N valid/ready requesters. It grants one requester at a time and holds the grant for a bounded burst of up to MAXB beats. Accepted beats load the shared output register, which presents out_data/out_vld to a single downstream consumer with backpressure. It sits in front of any shared pipeline register, and feeds a common FIFO or bus port.

---
 rtl/powlib_ffarb_pkg.sv | 18 +
 rtl/powlib_flipflop.sv | 22 ++
 rtl/powlib_rrpick.sv | 35 +++
 rtl/powlib_ffarb.sv | 99 +++++++++
 tb/tb_powlib_ffarb.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/powlib_ffarb_pkg.sv
// Shared definitions for the round-robin burst arbiter:
// FSM state encodings and a constant clog2 used for sizing.
package powlib_ffarb_pkg;

    typedef enum logic {
        PFFARB_IDLE  = 1'b0,
        PFFARB_GRANT = 1'b1
    } pffarb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Register with synchronous active-low reset to INIT and
// an optional load enable (EVLD=1 loads only when vld).
module powlib_flipflop #(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0,
    parameter bit           EVLD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         vld,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= INIT;
        else if (!EVLD || vld)
            q <= d;
    end

endmodule

// File: rtl/powlib_rrpick.sv
// Combinational round-robin picker: first set request
// found scanning from ptr upward, wrapping mod N.
module powlib_rrpick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        logic [IW-1:0] jj;
        j    = 0;
        jj   = '0;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any      = 1'b1;
                pick[jj] = 1'b1;
                idx      = jj;
            end
        end
    end

endmodule

// File: rtl/powlib_ffarb.sv
// Round-robin arbiter granting bounded bursts of up to MAXB
// beats from N requesters into one shared output register.
module powlib_ffarb
    import powlib_ffarb_pkg::*;
#(
    parameter int           W    = 8,
    parameter int           N    = 4,
    parameter int           MAXB = 4,
    parameter logic [W-1:0] INIT = '0,
    localparam int          IW   = (N > 1) ? clog2(N) : 1,
    localparam int          CW   = clog2(MAXB + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_vld,
    output logic [N-1:0]   in_rdy,
    output logic [W-1:0]   out_data,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [N-1:0]   gnt,
    output logic [IW-1:0]  gnt_idx
);

    pffarb_state_t state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic          any;
    logic          ld;
    logic          beat;
    logic          last;
    logic          vld_g;
    logic [W-1:0]  data_g;

    powlib_rrpick #(.N(N), .IW(IW)) u_pick (
        .req  (in_vld),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (any)
    );

    assign vld_g  = in_vld[gnt_idx];
    assign data_g = in_data[int'(gnt_idx)*W +: W];
    assign ld     = !out_vld || out_rdy;
    assign beat   = (state == PFFARB_GRANT) && vld_g && ld;
    assign last   = (cnt == CW'(MAXB - 1));
    assign in_rdy = (state == PFFARB_GRANT && ld) ? gnt : '0;
    assign ptr_nxt = (int'(gnt_idx) >= N - 1) ? '0 : gnt_idx + 1'b1;

    powlib_flipflop #(.W(W), .INIT(INIT), .EVLD(1'b1)) u_out (
        .clk (clk),
        .rst (rst),
        .d   (data_g),
        .vld (beat),
        .q   (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= PFFARB_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
        end else begin
            if (beat)
                out_vld <= 1'b1;
            else if (out_rdy)
                out_vld <= 1'b0;
            case (state)
                PFFARB_IDLE: begin
                    if (any) begin
                        gnt     <= pick;
                        gnt_idx <= pick_idx;
                        cnt     <= '0;
                        state   <= PFFARB_GRANT;
                    end
                end
                PFFARB_GRANT: begin
                    if (beat)
                        cnt <= cnt + 1'b1;
                    // a dropped valid also ends the burst
                    if ((beat && last) || !vld_g) begin
                        state <= PFFARB_IDLE;
                        gnt   <= '0;
                        ptr   <= ptr_nxt;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_powlib_ffarb.sv
// Directed and randomized checks of the burst round-robin arbiter.
module tb_powlib_ffarb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int MAXB = 2;
    localparam logic [7:0] INIT = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_vld = '0;
    logic [3:0]  in_rdy;
    logic [7:0]  out_data;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;

    int checks = 0;
    int errors = 0;

    int seq_in[4];
    int seq_out[4];
    int burst;

    powlib_ffarb #(.W(W), .N(N), .MAXB(MAXB), .INIT(INIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        in_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_vld = '0;
        out_rdy = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_vld !== 1'b0 || gnt !== 4'b0000 || in_rdy !== 4'b0000
                || out_data !== INIT || gnt_idx !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle c%0d: vld=%b gnt=%b rdy=%b data=%h idx=%0d want 0/0/0/%h/0",
                         c, out_vld, gnt, in_rdy, out_data, gnt_idx, INIT);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_vld = 4'b0001;
        set_data(0, 8'h77);
        tick();
        tick();
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'h77 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_pre: vld=%b data=%h gnt=%b want 1/77/0001",
                     out_vld, out_data, gnt);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_vld = '0;
        checks++;
        if (gnt !== 4'b0000 || out_vld !== 1'b0 || out_data !== INIT || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL midrst_post: gnt=%b vld=%b data=%h idx=%0d want 0000/0/%h/0",
                     gnt, out_vld, out_data, gnt_idx, INIT);
        end
    endtask

    task automatic test_stream();
        do_reset();
        in_vld = 4'b0100;
        set_data(2, 8'h10);
        #1;
        checks++;
        if (in_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL stream_idle_rdy: got %b want 0000", in_rdy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL stream_gnt: gnt=%b idx=%0d vld=%b want 0100/2/0", gnt, gnt_idx, out_vld);
        end
        #1;
        checks++;
        if (in_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL stream_rdy: got %b want 0100", in_rdy);
        end
        tick();
        checks++;
        if (out_data !== 8'h10 || out_vld !== 1'b1) begin
            errors++;
            $display("FAIL stream_b0: data=%h vld=%b want 10/1", out_data, out_vld);
        end
        set_data(2, 8'h11);
        tick();
        checks++;
        if (out_data !== 8'h11 || out_vld !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL stream_b1: data=%h vld=%b gnt=%b want 11/1/0000", out_data, out_vld, gnt);
        end
        set_data(2, 8'h12);
        #1;
        checks++;
        if (in_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL stream_bubble_rdy: got %b want 0000", in_rdy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL stream_regnt: gnt=%b vld=%b want 0100/0", gnt, out_vld);
        end
        tick();
        checks++;
        if (out_data !== 8'h12 || out_vld !== 1'b1) begin
            errors++;
            $display("FAIL stream_b2: data=%h vld=%b want 12/1", out_data, out_vld);
        end
        in_vld = '0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: gnt=%b vld=%b want 0000/0", gnt, out_vld);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] prevg;
        int n;
        do_reset();
        for (int i = 0; i < 4; i++)
            set_data(i, 8'(8'h50 + i));
        in_vld = 4'b1111;
        prevg = '0;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (gnt !== 4'b0000 && prevg === 4'b0000) begin
                checks++;
                if (gnt_idx !== 2'(n % 4) || gnt !== 4'(1 << (n % 4))) begin
                    errors++;
                    $display("FAIL rr_order #%0d: idx=%0d gnt=%b want idx %0d", n, gnt_idx, gnt, n % 4);
                end
                n++;
            end
            prevg = gnt;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 5", n);
        end
        in_vld = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_vld = 4'b0010;
        set_data(1, 8'h21);
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_gnt: got %b want 0010", gnt);
        end
        tick();
        checks++;
        if (out_data !== 8'h21 || out_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_b0: data=%h vld=%b want 21/1", out_data, out_vld);
        end
        set_data(1, 8'h22);
        out_rdy = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL bp_rdy0: got %b want 0000", in_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_data !== 8'h21 || out_vld !== 1'b1 || gnt !== 4'b0010 || in_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold c%0d: data=%h vld=%b gnt=%b rdy=%b want 21/1/0010/0000",
                         c, out_data, out_vld, gnt, in_rdy);
            end
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_rdy: got %b want 0010", in_rdy);
        end
        tick();
        checks++;
        if (out_data !== 8'h22 || out_vld !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL bp_b1: data=%h vld=%b gnt=%b want 22/1/0000", out_data, out_vld, gnt);
        end
        in_vld = '0;
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        in_vld = 4'b1000;
        set_data(3, 8'h33);
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL drop_gnt: gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
        end
        tick();
        checks++;
        if (out_data !== 8'h33 || out_vld !== 1'b1) begin
            errors++;
            $display("FAIL drop_b0: data=%h vld=%b want 33/1", out_data, out_vld);
        end
        in_vld = '0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd3 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL drop_rel: gnt=%b idx=%0d vld=%b want 0000/3/0", gnt, gnt_idx, out_vld);
        end
        set_data(1, 8'h44);
        set_data(3, 8'h55);
        in_vld = 4'b1010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            errors++;
            $display("FAIL drop_ptr: gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
        end
        in_vld = '0;
        tick();
        tick();
    endtask

    task automatic rand_cycle(input bit allow_new);
        logic [3:0] acc;
        logic [3:0] gb;
        logic       oh;
        logic [7:0] od;
        int         r;
        for (int i = 0; i < 4; i++) begin
            if (allow_new && !in_vld[i] && $urandom_range(0, 2) == 0) begin
                in_vld[i] = 1'b1;
                set_data(i, {2'(i), 6'(seq_in[i])});
            end
        end
        out_rdy = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        acc = in_vld & in_rdy;
        oh  = out_vld & out_rdy;
        od  = out_data;
        gb  = gnt;
        tick();
        checks++;
        if ((acc & ~gb) != 4'b0000 || $countones(acc) > 1) begin
            errors++;
            $display("FAIL rnd_accept: acc=%b gnt=%b", acc, gb);
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                seq_in[i]++;
                in_vld[i] = 1'b0;
            end
        end
        if (|acc) begin
            burst++;
            checks++;
            if (burst > MAXB) begin
                errors++;
                $display("FAIL rnd_burst: got %0d beats want <= %0d", burst, MAXB);
            end
        end
        if (gnt === 4'b0000)
            burst = 0;
        if (oh) begin
            r = int'(od[7:6]);
            checks++;
            if (od[5:0] !== 6'(seq_out[r])) begin
                errors++;
                $display("FAIL rnd_order req%0d: seq=%0d want %0d", r, od[5:0], seq_out[r] % 64);
            end
            seq_out[r]++;
        end
    endtask

    task automatic test_random();
        bit done;
        do_reset();
        burst = 0;
        for (int i = 0; i < 4; i++) begin
            seq_in[i] = 0;
            seq_out[i] = 0;
        end
        for (int c = 0; c < 10000; c++)
            rand_cycle(1'b1);
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            rand_cycle(1'b0);
            done = (in_vld == 4'b0000) && !out_vld;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq_out[i] != seq_in[i] || seq_in[i] == 0) begin
                errors++;
                $display("FAIL rnd_total req%0d: out=%0d want in=%0d (nonzero)", i, seq_out[i], seq_in[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_stream();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
